fmul_arbiter: RTL and testbench

- Shares one pipelined fmul unit (fixed latency, no stall, no valid of its own) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready issue handshake.
- A tag shift register matches each operation's tag to its result, so each result goes back to the requester that issued it.
- Sits between the FP register-read stage of each consumer (e.g. core FPU port, vector/DMA helper) and the single fmul instance.

---
 rtl/fmul_arbiter.sv | 144 ++++++++++++++
 tb/tb_fmul_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined fmul between NUM_REQ requesters.
// A {valid, tag} shift register follows each op through the multiplier and steers its result back.
module fmul_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 5,
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W = $clog2(LATENCY + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_x1,
    input  logic [32*NUM_REQ-1:0]   req_x2,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_y,
    output logic [31:0]             mul_x1,
    output logic [31:0]             mul_x2,
    input  logic [31:0]             mul_y,
    output logic [CNT_W-1:0]        inflight,
    output logic                    idle
);

    logic [TAG_W-1:0]   ptr_r;
    logic               found_s;
    logic [TAG_W-1:0]   gidx_s;
    logic [TAG_W-1:0]   cand_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [LATENCY-1:0] tag_vld_r;
    logic [TAG_W-1:0]   tag_idx_r [LATENCY];
    logic               last_vld_s;
    logic [TAG_W-1:0]   last_tag_s;
    logic [NUM_REQ-1:0] resp_next_s;
    logic [NUM_REQ-1:0] resp_valid_r;
    logic [31:0]        resp_y_r;
    logic [CNT_W-1:0]   inflight_r;

    // Round-robin search starting just after the last granted requester; rstn gating keeps grants off during reset.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = {TAG_W{1'b0}};
        cand_s  = {TAG_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = TAG_W'((int'(ptr_r) + k) % NUM_REQ);
            if (en && rstn && !found_s && req_valid[cand_s]) begin
                found_s = 1'b1;
                gidx_s  = cand_s;
            end else begin
            end
        end
    end

    // One-hot grant and operand mux; operands rest at zero when nothing is granted.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        mul_x1  = 32'h0000_0000;
        mul_x2  = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found_s && (gidx_s == TAG_W'(i))) begin
                grant_s[i] = 1'b1;
                mul_x1     = mul_x1 | req_x1[i*32 +: 32];
                mul_x2     = mul_x2 | req_x2[i*32 +: 32];
            end else begin
            end
        end
    end

    assign req_ready  = grant_s;
    assign idle       = (inflight_r == CNT_W'(0)) && !found_s;
    assign last_vld_s = tag_vld_r[LATENCY-1];
    assign last_tag_s = tag_idx_r[LATENCY-1];
    assign resp_valid = resp_valid_r;
    assign resp_y     = resp_y_r;
    assign inflight   = inflight_r;

    // Decode the tag leaving the pipe into the next response strobe.
    always_comb begin
        resp_next_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_vld_s && (last_tag_s == TAG_W'(i))) begin
                resp_next_s[i] = 1'b1;
            end else begin
            end
        end
    end

    // Round-robin pointer; reset value makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= TAG_W'(NUM_REQ - 1);
        end else if (found_s) begin
            ptr_r <= gidx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag pipe mirrors the fmul depth so the last stage lines up with mul_y.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                tag_idx_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= found_s;
            tag_idx_r[0] <= gidx_s;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_idx_r[i] <= tag_idx_r[i-1];
            end
        end
    end

    // Registered response; resp_y holds its last result between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_r <= {NUM_REQ{1'b0}};
            resp_y_r     <= 32'h0000_0000;
        end else begin
            resp_valid_r <= resp_next_s;
            if (last_vld_s) begin
                resp_y_r <= mul_y;
            end else begin
                resp_y_r <= resp_y_r;
            end
        end
    end

    // Outstanding-op counter; issue and retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_r <= CNT_W'(0);
        end else begin
            case ({found_s, last_vld_s})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter with a stub multiplier (y = x1 ^ x2 after LATENCY cycles).
module tb_fmul_arbiter;
    localparam int NR = 3;
    localparam int L  = 5;
    localparam int CW = $clog2(L + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [32*NR-1:0]  req_x1;
    logic [32*NR-1:0]  req_x2;
    logic [NR-1:0]     resp_valid;
    logic [31:0]       resp_y;
    logic [31:0]       mul_x1;
    logic [31:0]       mul_x2;
    logic [31:0]       mul_y;
    logic [CW-1:0]     inflight;
    logic              idle;

    fmul_arbiter #(.NUM_REQ(NR), .LATENCY(L)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2),
        .resp_valid(resp_valid), .resp_y(resp_y),
        .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Stub fmul: free-running, never reset, so stale results survive a reset.
    logic [31:0] pipe [L];
    initial for (int i = 0; i < L; i++) pipe[i] = 32'h0;
    always @(posedge clk) begin
        pipe[0] <= mul_x1 ^ mul_x2;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_y = pipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; logic [31:0] y; int issue; int due; } ent_t;
    ent_t sbq[$];

    int checks = 0;
    int failures = 0;
    int ptr = NR - 1;
    int max_inf = 0;
    logic [32*NR-1:0] nx1, nx2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: grant = first valid requester after the last winner, wrapping.
    task automatic check_cycle();
        int g;
        int n;
        logic [NR-1:0] eg;
        ent_t e;
        g = -1;
        if (en && rstn) begin
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        n = 0;
        foreach (sbq[j]) if (sbq[j].issue < cyc && sbq[j].issue + L >= cyc) n++;
        if (int'(inflight) > max_inf) max_inf = int'(inflight);
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("mul_x1", mul_x1, (g >= 0) ? req_x1[g*32 +: 32] : 32'h0);
        chk("mul_x2", mul_x2, (g >= 0) ? req_x2[g*32 +: 32] : 32'h0);
        chk("inflight", 32'(inflight), 32'(n));
        chk("idle", 32'(idle), 32'((n == 0) && (g < 0)));
        if (g >= 0) begin
            e.idx = g; e.y = req_x1[g*32 +: 32] ^ req_x2[g*32 +: 32];
            e.issue = cyc; e.due = cyc + L + 1;
            sbq.push_back(e);
            ptr = g;
        end
    endtask

    task automatic step(input logic [NR-1:0] v, input logic e);
        @(posedge clk);
        #1;
        req_valid = v; en = e; req_x1 = nx1; req_x2 = nx2;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            nx1[i*32 +: 32] = $urandom;
            nx2[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            step('0, 1'b1);
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
        step('0, 1'b1);
    endtask

    // Monitor: every response must match the oldest outstanding op, on time.
    always @(negedge clk) begin
        ent_t e;
        logic [NR-1:0] ev;
        if (rstn) begin
            if (resp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    ev = '0; ev[e.idx] = 1'b1;
                    chk("resp_valid", 32'(resp_valid), 32'(ev));
                    chk("resp_y", resp_y, e.y);
                    chk("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("resp_missing", 32'(resp_valid), 32'(1 << e.idx));
            end
        end
    end

    initial begin
        rstn = 1'b0; en = 1'b0; req_valid = '0; req_x1 = '0; req_x2 = '0;
        nx1 = '0; nx2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_y", resp_y, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        @(posedge clk); #1 rstn = 1'b1;

        // Single op
        nx1[31:0] = 32'h3F80_0000; nx2[31:0] = 32'h4000_0000;
        step(3'b001, 1'b1);
        nx1 = '0; nx2 = '0;
        drain();

        // Contention between req0 and req1
        for (int i = 0; i < 4; i++) begin rand_ops(); step(3'b011, 1'b1); end
        drain();

        // Back-to-back saturation on req1
        max_inf = 0;
        for (int i = 0; i < 10; i++) begin rand_ops(); step(3'b010, 1'b1); end
        drain();
        chk("inflight_peak", 32'(max_inf), 32'(L));

        // en gating with an op already in flight
        rand_ops(); step(3'b001, 1'b1);
        for (int i = 0; i < 3; i++) begin rand_ops(); step(3'b001, 1'b0); end
        rand_ops(); step(3'b001, 1'b1);
        drain();

        // Wrap-around: last grant req2, then req0 before req2
        rand_ops(); step(3'b100, 1'b1);
        rand_ops(); step(3'b101, 1'b1);
        rand_ops(); step(3'b101, 1'b1);
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            step(NR'($urandom_range(0, (1 << NR) - 1)), ($urandom_range(0, 9) != 0));
        end
        drain();

        // Async reset with ops in flight
        for (int i = 0; i < 3; i++) begin rand_ops(); step(3'b001, 1'b1); end
        step('0, 1'b1);
        step('0, 1'b1);
        @(posedge clk);
        #3;
        rstn = 1'b0; req_valid = 3'b011; en = 1'b1;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_resp_y", resp_y, 32'h0);
        chk("arst_inflight", 32'(inflight), 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        sbq.delete();
        ptr = NR - 1;
        @(posedge clk); #1 rstn = 1'b1; req_valid = '0;
        rand_ops(); step(3'b011, 1'b1);
        for (int i = 0; i < 10; i++) step('0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
